// File: rtl/ovrd_pipelined_shaper.sv
// Four-stage overdrive waveshaper: pre-gain, then bypass/hard/cubic/asymmetric shaping,
// with valid/ready flow control and a saturating clip-event counter.
module ovrd_pipelined_shaper #(
  parameter int bits_per_level = 12,
  parameter int fxp_size       = 32,
  parameter int channels       = 2,
  parameter int clip_cnt_size  = 16,
  localparam int CW = (channels > 1) ? $clog2(channels) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic signed [fxp_size-1:0] i_sample,
  input  logic [CW-1:0]              i_channel,
  input  logic [1:0]                 i_mode,
  input  logic signed [fxp_size-1:0] i_gain,
  input  logic signed [fxp_size-1:0] i_threshold,
  input  logic                       i_clear,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic signed [fxp_size-1:0] o_sample,
  output logic [CW-1:0]              o_channel,
  output logic [clip_cnt_size-1:0]   o_clip_count
);

  localparam int W  = fxp_size;
  localparam int W2 = 2 * fxp_size;
  localparam logic signed [W-1:0]  FXP_ONE   = W'(1) << bits_per_level;
  localparam logic signed [W-1:0]  FXP_THIRD = FXP_ONE / $signed(W'(3));
  localparam logic signed [W-1:0]  FXP_CL    = FXP_ONE - FXP_THIRD;
  localparam logic signed [W-1:0]  FXP_NCL   = -FXP_CL;
  localparam logic [W:0]           ONE_MAG   = {1'b0, FXP_ONE};
  localparam logic signed [W2-1:0] SAT_MAX   = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [W2-1:0] SAT_MIN   = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  function automatic logic signed [W2-1:0] sext(input logic signed [W-1:0] v);
    sext = {{W{v[W-1]}}, v};
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [W2-1:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[W-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[W-1:0];
    else                  sat = v[W-1:0];
  endfunction

  // One extra bit so that |most-negative| is representable.
  function automatic logic [W:0] mag(input logic signed [W-1:0] v);
    logic signed [W:0] e;
    e   = {v[W-1], v};
    mag = e[W] ? -e : e;
  endfunction

  // Handshake: a sample is accepted when i_valid & o_ready, and leaves when
  // o_valid & i_ready. Every stage shifts together when the output register is
  // empty or being drained; otherwise the whole pipe holds, outputs included.
  logic w_adv;
  assign w_adv   = !o_valid || i_ready;
  assign o_ready = w_adv;

  logic [CW-1:0] w_ch_in;
  assign w_ch_in = (channels > 1) ? i_channel : '0;

  // Stage 1: pre-gain
  logic signed [W-1:0] w_g1;
  assign w_g1 = sat((sext(i_sample) * sext(i_gain)) >>> bits_per_level);

  logic                r_v1;
  logic signed [W-1:0] r_g1;
  logic [1:0]          r_mode1;
  logic [W:0]          r_thr1;
  logic [CW-1:0]       r_ch1;

  // Stage 2: square and range flags
  logic signed [W-1:0] w_sq2;
  logic [W:0]          w_gmag2;
  assign w_sq2   = sat((sext(r_g1) * sext(r_g1)) >>> bits_per_level);
  assign w_gmag2 = mag(r_g1);

  logic                r_v2;
  logic signed [W-1:0] r_g2;
  logic signed [W-1:0] r_sq2;
  logic [1:0]          r_mode2;
  logic [W:0]          r_thr2;
  logic [CW-1:0]       r_ch2;
  logic                r_one2;
  logic                r_hit2;

  // Stage 3: cube scaled by one third
  logic signed [W2-1:0] w_cb3;
  logic signed [W-1:0]  w_t3;
  assign w_cb3 = (sext(r_sq2) * sext(r_g2)) >>> bits_per_level;
  assign w_t3  = W'((w_cb3 * sext(FXP_THIRD)) >>> bits_per_level);

  logic                r_v3;
  logic signed [W-1:0] r_g3;
  logic signed [W-1:0] r_t3;
  logic [1:0]          r_mode3;
  logic [W:0]          r_thr3;
  logic [CW-1:0]       r_ch3;
  logic                r_one3;
  logic                r_hit3;

  // Stage 4: shaping select
  logic                w_neg3;
  logic signed [W-1:0] w_thr_neg3;
  logic signed [W-1:0] w_hard_res;
  logic signed [W-1:0] w_soft_res;
  logic signed [W-1:0] w_res4;
  logic                w_clip4;

  assign w_neg3     = r_g3[W-1];
  assign w_thr_neg3 = W'(-r_thr3);
  assign w_hard_res = r_hit3 ? (w_neg3 ? w_thr_neg3 : $signed(r_thr3[W-1:0])) : r_g3;
  assign w_soft_res = r_one3 ? (w_neg3 ? FXP_NCL : FXP_CL) : (r_g3 - r_t3);

  always_comb begin
    w_res4  = r_g3;
    w_clip4 = 1'b0;
    case (r_mode3)
      2'd1: begin
        w_res4  = w_hard_res;
        w_clip4 = r_hit3;
      end
      2'd2: begin
        w_res4  = w_soft_res;
        w_clip4 = r_one3;
      end
      2'd3: begin
        w_res4  = w_neg3 ? w_hard_res : w_soft_res;
        w_clip4 = w_neg3 ? r_hit3 : r_one3;
      end
      default: ;
    endcase
  end

  logic                     r_valid;
  logic signed [W-1:0]      r_sample;
  logic [CW-1:0]            r_channel;
  logic                     r_clip4;
  logic [clip_cnt_size-1:0] r_clip_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0; r_g1 <= '0; r_mode1 <= '0; r_thr1 <= '0; r_ch1 <= '0;
      r_v2 <= 1'b0; r_g2 <= '0; r_sq2 <= '0; r_mode2 <= '0; r_thr2 <= '0; r_ch2 <= '0;
      r_one2 <= 1'b0; r_hit2 <= 1'b0;
      r_v3 <= 1'b0; r_g3 <= '0; r_t3 <= '0; r_mode3 <= '0; r_thr3 <= '0; r_ch3 <= '0;
      r_one3 <= 1'b0; r_hit3 <= 1'b0;
      r_valid <= 1'b0; r_sample <= '0; r_channel <= '0; r_clip4 <= 1'b0;
    end else if (w_adv) begin
      r_v1    <= i_valid;
      r_g1    <= w_g1;
      r_mode1 <= i_mode;
      r_thr1  <= mag(i_threshold);
      r_ch1   <= w_ch_in;

      r_v2    <= r_v1;
      r_g2    <= r_g1;
      r_sq2   <= w_sq2;
      r_mode2 <= r_mode1;
      r_thr2  <= r_thr1;
      r_ch2   <= r_ch1;
      r_one2  <= (w_gmag2 >= ONE_MAG);
      r_hit2  <= (w_gmag2 >= r_thr1);

      r_v3    <= r_v2;
      r_g3    <= r_g2;
      r_t3    <= w_t3;
      r_mode3 <= r_mode2;
      r_thr3  <= r_thr2;
      r_ch3   <= r_ch2;
      r_one3  <= r_one2;
      r_hit3  <= r_hit2;

      r_valid   <= r_v3;
      r_sample  <= w_res4;
      r_channel <= r_ch3;
      r_clip4   <= r_v3 && w_clip4;
    end
  end

  // Clear beats a coincident increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_clip_cnt <= '0;
    end else if (r_valid && i_ready && r_clip4 && (r_clip_cnt != '1)) begin
      r_clip_cnt <= r_clip_cnt + 1'b1;
    end
  end

  assign o_valid      = r_valid;
  assign o_sample     = r_sample;
  assign o_channel    = r_channel;
  assign o_clip_count = r_clip_cnt;

endmodule

// File: tb/tb_ovrd_pipelined_shaper.sv
// Bench for ovrd_pipelined_shaper: directed and random samples scored against a
// longint reference model through an expected-output queue.
module tb_ovrd_pipelined_shaper;

  localparam int W  = 32;
  localparam int CW = 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                i_valid = 1'b0;
  logic                o_ready;
  logic signed [W-1:0] i_sample = '0;
  logic [CW-1:0]       i_channel = '0;
  logic [1:0]          i_mode = '0;
  logic signed [W-1:0] i_gain = '0;
  logic signed [W-1:0] i_threshold = '0;
  logic                i_clear = 1'b0;
  logic                o_valid;
  logic                i_ready = 1'b1;
  logic signed [W-1:0] o_sample;
  logic [CW-1:0]       o_channel;
  logic [15:0]         o_clip_count;

  ovrd_pipelined_shaper #(
    .bits_per_level(12), .fxp_size(W), .channels(2), .clip_cnt_size(16)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_sample(i_sample), .i_channel(i_channel), .i_mode(i_mode),
    .i_gain(i_gain), .i_threshold(i_threshold), .i_clear(i_clear),
    .o_valid(o_valid), .i_ready(i_ready), .o_sample(o_sample),
    .o_channel(o_channel), .o_clip_count(o_clip_count)
  );

  // clock / watchdog
  initial forever #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int checks = 0;
  int failures = 0;
  logic [W+CW:0] exp_q[$];   // {clip, channel, sample}
  int m_cnt = 0;
  bit mon_en = 1'b0;
  bit stall_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", name, got, $signed(got), exp, $signed(exp));
    end
  endtask

  // reference model
  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  function automatic void model(input int x, input int gain, input int mode, input int thr,
                                output int res, output bit clip);
    longint g, ag, athr, sq, cb, t, r;
    g    = sat32((longint'(x) * longint'(gain)) >>> 12);
    ag   = (g < 0) ? -g : g;
    athr = (thr < 0) ? -longint'(thr) : longint'(thr);
    sq   = sat32((g * g) >>> 12);
    cb   = (sq * g) >>> 12;
    t    = (cb * 1365) >>> 12;
    clip = 1'b0;
    r    = g;
    if (mode == 1 || (mode == 3 && g < 0)) begin
      if (ag >= athr) begin
        clip = 1'b1;
        r = (g < 0) ? -athr : athr;
      end
    end else if (mode == 2 || mode == 3) begin
      if (g >= 4096) begin
        clip = 1'b1; r = 2731;
      end else if (g <= -4096) begin
        clip = 1'b1; r = -2731;
      end else begin
        r = g - t;
      end
    end
    res = int'(r);
  endfunction

  // ready randomiser
  initial forever begin
    @(posedge clk); #1;
    i_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // driver tasks (called at posedge+1)
  task automatic send(input int x, input int gain, input int mode, input int thr, input int ch);
    int res;
    bit clip;
    int w;
    i_valid     = 1'b1;
    i_sample    = x;
    i_gain      = gain;
    i_mode      = mode[1:0];
    i_threshold = thr;
    i_channel   = ch[CW-1:0];
    model(x, gain, mode, thr, res, clip);
    w = 0;
    @(negedge clk);
    while (!o_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (!o_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout: o_ready stayed 0 for %0d cycles", w);
    end else begin
      exp_q.push_back({clip, ch[CW-1:0], res});
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d outputs missing, expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_pulse();
    i_clear = 1'b1;
    @(posedge clk); #1;
    i_clear = 1'b0;
  endtask

  task automatic latency_probe(input int x, input int ch, input int exp_s);
    send(x, 4096, 2, 0, ch);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("latency_valid", {31'b0, o_valid}, {31'b0, (k == 3)});
    end
    check("latency_sample", o_sample, exp_s);
  endtask

  // monitor / scoreboard
  logic [W+CW:0] mon_e;
  bit            mon_clip;
  bit            prev_stall = 1'b0;
  logic [W-1:0]  prev_s;
  logic [CW-1:0] prev_c;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_clip = 1'b0;
      check("clip_count", {16'b0, o_clip_count}, m_cnt);
      if (prev_stall) begin
        check("stall_valid", {31'b0, o_valid}, 32'd1);
        check("stall_sample", o_sample, prev_s);
        check("stall_channel", {31'b0, o_channel}, {31'b0, prev_c});
      end
      if (!rst && o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output: sample 0x%08h with no queued expectation", o_sample);
        end else begin
          mon_e = exp_q.pop_front();
          check("sample", o_sample, mon_e[W-1:0]);
          check("channel", {31'b0, o_channel}, {31'b0, mon_e[W]});
          mon_clip = mon_e[W+1];
        end
      end
      if (rst || i_clear) m_cnt = 0;
      else if (mon_clip && m_cnt < 65535) m_cnt++;
      if (rst) exp_q.delete();
      prev_stall = !rst && o_valid && !i_ready;
      prev_s = o_sample;
      prev_c = o_channel;
    end
  end

  // main sequence
  initial begin
    int x, g, thr, n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_o_valid", {31'b0, o_valid}, 32'd0);
    check("rst_o_ready", {31'b0, o_ready}, 32'd1);
    check("rst_o_sample", o_sample, 32'd0);
    check("rst_o_channel", {31'b0, o_channel}, 32'd0);
    check("rst_clip_count", {16'b0, o_clip_count}, 32'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    latency_probe(2048, 0, 1878);
    drain();
    latency_probe(-2048, 1, -1877);
    drain();

    send(8192, 4096, 2, 0, 0);
    send(-8192, 4096, 2, 0, 1);
    drain();
    check("mode2_clip_count", {16'b0, o_clip_count}, 32'd2);

    clear_pulse();
    send(5000, 4096, 1, 3000, 0);
    send(-5000, 4096, 1, 3000, 1);
    send(100, 4096, 1, 3000, 0);
    drain();
    check("mode1_clip_count", {16'b0, o_clip_count}, 32'd2);

    send(1 << 30, 32768, 0, 0, 1);
    send(7, -4096, 0, 0, 0);
    drain();

    stall_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      x = int'($urandom_range(0, 20000)) - 10000;
      send(x, 4096, (i % 2 == 1) ? 1 : 2, 2500, i % 2);
    end
    drain();

    for (int i = 0; i < 300; i++) begin
      x   = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 24000)) - 12000;
      g   = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 24576)) - 12288;
      thr = ($urandom_range(0, 7) == 0) ? int'($urandom) : int'($urandom_range(0, 12000)) - 6000;
      send(x, g, int'($urandom_range(0, 3)), thr, int'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();
    stall_en = 1'b0;

    clear_pulse();
    for (int i = 0; i < 65537; i++) send(8192, 4096, 2, 0, i % 2);
    drain();
    check("sat_clip_count", {16'b0, o_clip_count}, 32'd65535);

    send(8192, 4096, 2, 0, 0);
    send(-8192, 4096, 3, 0, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_o_valid", {31'b0, o_valid}, 32'd0);
    check("midrst_o_sample", o_sample, 32'd0);
    check("midrst_clip_count", {16'b0, o_clip_count}, 32'd0);
    @(posedge clk); #1;

    send(8192, 4096, 2, 0, 0);
    drain();
    check("one_clip_count", {16'b0, o_clip_count}, 32'd1);
    send(-8192, 4096, 2, 0, 1);
    n = 0;
    while (!o_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!o_valid) begin
      failures++;
      $display("FAIL clear_wait: o_valid got 0 expected 1 within 10 cycles");
    end
    i_clear = 1'b1;
    @(posedge clk); #1;
    i_clear = 1'b0;
    @(negedge clk);
    check("clear_priority_count", {16'b0, o_clip_count}, 32'd0);
    @(posedge clk); #1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
